// File: rtl/montmult_arbiter.sv
// rtl/montmult_arbiter.sv - round-robin arbiter sharing one Montgomery multiplier between NREQ requesters
module montmult_arbiter #(
    parameter int WIDTH = 1024,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       rsp_done,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  busy,
    output logic [IDW-1:0]        grant_id,
    output logic                  mult_start,
    output logic [WIDTH-1:0]      mult_a,
    output logic [WIDTH-1:0]      mult_b,
    input  logic [WIDTH-1:0]      mult_result,
    input  logic                  mult_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]    grant_id_q, grant_id_d;
    logic [WIDTH-1:0]  mult_a_q, mult_a_d;
    logic [WIDTH-1:0]  mult_b_q, mult_b_d;
    logic              mult_start_q, mult_start_d;
    logic              busy_q, busy_d;
    logic [NREQ-1:0]   rsp_done_q, rsp_done_d;
    logic [WIDTH-1:0]  rsp_result_q, rsp_result_d;

    // Round-robin pick: first asserted request at or after rr_ptr, wrapping at NREQ
    logic              sel_found;
    logic [IDW-1:0]    sel_idx;
    logic [IDW:0]      scan_sum;

    // Pointer to the requester after the one being served, wrapping at NREQ
    logic [IDW:0]      ptr_inc;
    logic [IDW-1:0]    ptr_next;

    localparam logic [IDW:0]    NREQ_W  = (IDW+1)'(NREQ);
    localparam logic [NREQ-1:0] ONE_HOT = {{(NREQ-1){1'b0}}, 1'b1};

    // Scan requests starting at the round-robin pointer; the first hit wins
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_sum  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (scan_sum >= NREQ_W) begin
                scan_sum = scan_sum - NREQ_W;
            end
            if (!sel_found && req[scan_sum[IDW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = scan_sum[IDW-1:0];
            end
        end
    end

    // Successor of the served requester becomes the highest-priority slot
    always_comb begin
        ptr_inc = {1'b0, grant_id_q} + (IDW+1)'(1);
        if (ptr_inc >= NREQ_W) begin
            ptr_inc = '0;
        end
        ptr_next = ptr_inc[IDW-1:0];
    end

    // Next-state and registered-output logic; everything holds unless a state acts on it
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        mult_a_d     = mult_a_q;
        mult_b_d     = mult_b_q;
        mult_start_d = 1'b0;
        busy_d       = busy_q;
        rsp_done_d   = rsp_done_q;
        rsp_result_d = rsp_result_q;

        case (state_q)
            S_IDLE: begin
                // Operands are captured here, so the requester may change them afterwards
                if (sel_found) begin
                    grant_id_d   = sel_idx;
                    mult_a_d     = req_a[int'(sel_idx)*WIDTH +: WIDTH];
                    mult_b_d     = req_b[int'(sel_idx)*WIDTH +: WIDTH];
                    mult_start_d = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                // The grant is committed: a dropped req does not cancel the response
                if (mult_done) begin
                    rsp_result_d = mult_result;
                    rsp_done_d   = ONE_HOT << grant_id_q;
                    rr_ptr_d     = ptr_next;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                rsp_done_d = '0;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                rsp_done_d = '0;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight multiply silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            grant_id_q   <= '0;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            mult_start_q <= 1'b0;
            busy_q       <= 1'b0;
            rsp_done_q   <= '0;
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            mult_a_q     <= mult_a_d;
            mult_b_q     <= mult_b_d;
            mult_start_q <= mult_start_d;
            busy_q       <= busy_d;
            rsp_done_q   <= rsp_done_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign rsp_done   = rsp_done_q;
    assign rsp_result = rsp_result_q;
    assign busy       = busy_q;
    assign grant_id   = grant_id_q;
    assign mult_start = mult_start_q;
    assign mult_a     = mult_a_q;
    assign mult_b     = mult_b_q;

endmodule

// File: tb/tb_montmult_arbiter.sv
// tb/tb_montmult_arbiter.sv - self-checking bench for montmult_arbiter with a behavioural montmult
module tb_montmult_arbiter;

    localparam int W  = 16;
    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req;
    logic [NR*W-1:0] req_a;
    logic [NR*W-1:0] req_b;
    logic [NR-1:0]   rsp_done;
    logic [W-1:0]    rsp_result;
    logic            busy;
    logic [1:0]      grant_id;
    logic            mult_start;
    logic [W-1:0]    mult_a;
    logic [W-1:0]    mult_b;
    logic [W-1:0]    mult_result;
    logic            mult_done;

    logic [W-1:0]    a_v [NR];
    logic [W-1:0]    b_v [NR];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: round-robin pointer, grant history, last response
    int       m_ptr;
    int       hist[$];
    int       m_last_id;
    logic [W-1:0] m_last_res;

    montmult_arbiter #(.WIDTH(W), .NREQ(NR), .IDW(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
        .rsp_done(rsp_done), .rsp_result(rsp_result), .busy(busy), .grant_id(grant_id),
        .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .mult_result(mult_result), .mult_done(mult_done)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NR; i++) begin
            req_a[i*W +: W] = a_v[i];
            req_b[i*W +: W] = b_v[i];
        end
    end

    function automatic int rr_pick(input logic [NR-1:0] r, input int ptr);
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (ptr + k) % NR;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] mm_model(input logic [W-1:0] a, input logic [W-1:0] b);
        return W'((32'(a) * 32'(b)) % 97);
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        mult_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        hist.delete();
        m_last_id  = 0;
        m_last_res = '0;
    endtask

    // Serve one transaction as montmult with latency lat; predicts winner, operands, timing and result
    task automatic serve(input int lat, input logic [NR-1:0] mid_drop, input logic [NR-1:0] end_drop,
                         input bit resp_pulse, input string tag);
        bit found = 0;
        int id;
        logic [W-1:0] ea, eb, er;
        for (int t = 0; t < 30 && !found; t++) begin
            @(negedge clk);
            if (mult_start === 1'b1) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s start_timeout: mult_start never rose, req=%b", tag, req);
            return;
        end
        id = rr_pick(req, m_ptr);
        n_checks++;
        if (id < 0) begin
            n_fail++;
            $display("FAIL %s spurious_grant: got grant_id=%0d, required no grant", tag, grant_id);
            return;
        end
        ea = a_v[id];
        eb = b_v[id];
        er = mm_model(ea, eb);
        n_checks++;
        if (grant_id !== 2'(id)) begin
            n_fail++; $display("FAIL %s grant_id: got %0d required %0d", tag, grant_id, id);
        end
        n_checks++;
        if (mult_a !== ea || mult_b !== eb) begin
            n_fail++; $display("FAIL %s operands: got a=%0d b=%0d required a=%0d b=%0d", tag, mult_a, mult_b, ea, eb);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL %s busy_at_start: got %b required 1", tag, busy);
        end
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_checks++;
                if (mult_start !== 1'b0) begin
                    n_fail++; $display("FAIL %s start_width: got mult_start=%b required 0", tag, mult_start);
                end
                req = req & ~mid_drop;
                for (int i = 0; i < NR; i++) if (mid_drop[i]) a_v[i] = '0;
            end
            n_checks++;
            if (rsp_done !== '0 || busy !== 1'b1) begin
                n_fail++; $display("FAIL %s wait_cycle%0d: got rsp_done=%b busy=%b required 0000/1", tag, c, rsp_done, busy);
            end
            if (c == lat) begin
                mult_done   = 1'b1;
                mult_result = er;
            end
        end
        @(negedge clk);
        if (resp_pulse) mult_result = ~er;
        else mult_done = 1'b0;
        n_checks++;
        if (rsp_done !== (4'b0001 << id) || rsp_result !== er || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s response: got rsp_done=%b result=%0d busy=%b required %b %0d 1",
                     tag, rsp_done, rsp_result, busy, 4'b0001 << id, er);
        end
        m_ptr = (id + 1) % NR;
        hist.push_back(id);
        m_last_id  = id;
        m_last_res = er;
        req = req & ~end_drop;
        @(negedge clk);
        mult_done = 1'b0;
        n_checks++;
        if (rsp_done !== '0 || busy !== 1'b0 || rsp_result !== er || grant_id !== 2'(id)) begin
            n_fail++;
            $display("FAIL %s after_resp: got rsp_done=%b busy=%b result=%0d grant=%0d required 0000 0 %0d %0d",
                     tag, rsp_done, busy, rsp_result, grant_id, er, id);
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_checks++;
        if (mult_start !== 1'b0 || rsp_done !== '0 || busy !== 1'b0 || grant_id !== '0 ||
            mult_a !== '0 || mult_b !== '0 || rsp_result !== '0) begin
            n_fail++;
            $display("FAIL %s: got start=%b done=%b busy=%b gid=%0d a=%0d b=%0d res=%0d required all zero",
                     tag, mult_start, rsp_done, busy, grant_id, mult_a, mult_b, rsp_result);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = '0;
        mult_done = 1'b0;
        mult_result = '0;
        for (int i = 0; i < NR; i++) begin a_v[i] = '0; b_v[i] = '0; end
        @(negedge clk);
        check_all_zero("reset_state");
        do_reset();
    endtask

    task automatic test_single();
        a_v[2] = 16'd3;
        b_v[2] = 16'd5;
        req = 4'b0100;
        serve(4, '0, 4'b0100, 0, "single");
        n_checks++;
        if (m_last_res !== 16'd15) begin
            n_fail++; $display("FAIL single_value: got %0d required 15", m_last_res);
        end
    endtask

    task automatic test_all_four();
        do_reset();
        for (int i = 0; i < NR; i++) begin a_v[i] = W'($urandom); b_v[i] = W'($urandom); end
        req = 4'b1111;
        for (int g = 0; g < 6; g++)
            serve(int'($urandom_range(1, 6)), '0, (g == 5) ? 4'b1111 : 4'b0000, 0, "all_four");
        for (int g = 0; g < hist.size(); g++) begin
            n_checks++;
            if (hist[g] !== g % NR) begin
                n_fail++; $display("FAIL rr_order[%0d]: got %0d required %0d", g, hist[g], g % NR);
            end
        end
        for (int g = 0; g + 3 < hist.size(); g++) begin
            n_checks++;
            if (hist[g] == hist[g+1] || hist[g] == hist[g+2] || hist[g] == hist[g+3] ||
                hist[g+1] == hist[g+2] || hist[g+1] == hist[g+3] || hist[g+2] == hist[g+3]) begin
                n_fail++; $display("FAIL fairness_window%0d: got repeat in %0d %0d %0d %0d required distinct",
                                   g, hist[g], hist[g+1], hist[g+2], hist[g+3]);
            end
        end
    endtask

    task automatic test_drop_mid_wait();
        a_v[1] = W'($urandom_range(1, 65535));
        b_v[1] = W'($urandom_range(1, 65535));
        req = 4'b0010;
        serve(5, 4'b0010, 4'b0000, 0, "drop_mid_wait");
    endtask

    task automatic test_spurious();
        req = '0;
        @(negedge clk);
        mult_done   = 1'b1;
        mult_result = W'($urandom);
        @(negedge clk);
        mult_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (rsp_done !== '0 || busy !== 1'b0 || mult_start !== 1'b0 ||
                grant_id !== 2'(m_last_id) || rsp_result !== m_last_res) begin
                n_fail++;
                $display("FAIL spurious_idle%0d: got done=%b busy=%b start=%b gid=%0d res=%0d required 0000 0 0 %0d %0d",
                         c, rsp_done, busy, mult_start, grant_id, rsp_result, m_last_id, m_last_res);
            end
            @(negedge clk);
        end
        a_v[0] = W'($urandom); b_v[0] = W'($urandom);
        req = 4'b0001;
        serve(2, '0, 4'b0001, 1, "spurious_resp");
        for (int i = 0; i < NR; i++) begin a_v[i] = W'($urandom); b_v[i] = W'($urandom); end
        req = 4'b1111;
        serve(3, '0, 4'b1111, 0, "ptr_after_spurious");
    endtask

    task automatic test_reset_mid_wait();
        bit found = 0;
        a_v[3] = W'($urandom); b_v[3] = W'($urandom);
        req = 4'b1000;
        for (int t = 0; t < 30 && !found; t++) begin
            @(negedge clk);
            if (mult_start === 1'b1) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL reset_wait_start: mult_start never rose");
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        check_all_zero("held_reset");
        rst_n = 1'b1;
        m_ptr = 0;
        serve(3, '0, 4'b1000, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < NR; i++) begin a_v[i] = W'($urandom); b_v[i] = W'($urandom); end
        hist.delete();
        req = 4'b0011;
        serve(int'($urandom_range(1, 4)), '0, 4'b0001, 0, "b2b_first");
        req[0] = 1'b1;
        serve(int'($urandom_range(1, 4)), '0, 4'b0010, 0, "b2b_second");
        serve(int'($urandom_range(1, 4)), '0, 4'b0001, 0, "b2b_third");
        n_checks++;
        if (hist.size() != 3 || hist[0] != 0 || hist[1] != 1 || hist[2] != 0) begin
            n_fail++; $display("FAIL b2b_order: got %p required '{0, 1, 0}", hist);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_drop_mid_wait();
        test_spurious();
        test_reset_mid_wait();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
